// File: rtl/regfile_stack.sv
// Register-file LIFO stack for the calculator datapath.
// One push, pop, or replace per clock. Occupancy and full/empty status are
// reported, along with sticky overflow/underflow flags. The top two entries
// and an indexed peek port are read combinationally from the registered state.
module regfile_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PTR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  input  logic [PTR_W-1:0] peek_idx,
  output logic [WIDTH-1:0] stack_top,
  output logic [WIDTH-1:0] stack_top_minus_one,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] stack_ptr,
  output logic             overflow,
  output logic             underflow,
  output logic [WIDTH-1:0] peek_data
);

  // Address width of the storage array. The pointer may be one bit wider,
  // because it must be able to represent DEPTH itself.
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PtrDepth = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PtrTwo   = PTR_W'(2);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] stack_ptr_q, stack_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             set_ovf;
  logic             set_unf;

  // Status flags are always derived from the pointer, so they can never disagree.
  assign full  = (stack_ptr_q == PtrDepth);
  assign empty = (stack_ptr_q == '0);

  // Command decode: pick the write port action, the next pointer, and the error events.
  always_comb begin
    mem_we      = 1'b0;
    mem_waddr   = '0;
    stack_ptr_d = stack_ptr_q;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    // Combinations where full and empty are both set cannot occur; they fall to hold.
    case ({push, pop, full, empty})
      // Push onto a stack that is not full.
      4'b1000, 4'b1001: begin
        mem_we      = 1'b1;
        mem_waddr   = AW'(stack_ptr_q);
        stack_ptr_d = stack_ptr_q + PtrOne;
      end
      // Push onto a full stack: rejected.
      4'b1010: begin
        set_ovf = 1'b1;
      end
      // Pop from a stack that is not empty. The popped entry is left in place.
      4'b0100, 4'b0110: begin
        stack_ptr_d = stack_ptr_q - PtrOne;
      end
      // Pop from an empty stack: rejected.
      4'b0101: begin
        set_unf = 1'b1;
      end
      // Push and pop together on a stack that is not empty: overwrite the top.
      4'b1100, 4'b1110: begin
        mem_we    = 1'b1;
        mem_waddr = AW'(stack_ptr_q - PtrOne);
      end
      // Push and pop together on an empty stack: behave as a plain push.
      4'b1101: begin
        mem_we      = 1'b1;
        mem_waddr   = '0;
        stack_ptr_d = PtrOne;
      end
      default: begin
        stack_ptr_d = stack_ptr_q;
      end
    endcase
  end

  // Sticky error flags. When an error and clr_err arrive together, the error wins.
  always_comb begin
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (set_ovf) overflow_d  = 1'b1;
    if (set_unf) underflow_d = 1'b1;
  end

  // Control state, with synchronous active-low reset that overrides any command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stack_ptr_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      stack_ptr_q <= stack_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array: not reset, and only written while out of reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= data_in;
    end
  end

  // Read ports: entries at or above the pointer are masked to zero.
  always_comb begin
    stack_top           = '0;
    stack_top_minus_one = '0;
    peek_data           = '0;
    if (stack_ptr_q >= PtrOne) begin
      stack_top = mem_q[AW'(stack_ptr_q - PtrOne)];
    end
    if (stack_ptr_q >= PtrTwo) begin
      stack_top_minus_one = mem_q[AW'(stack_ptr_q - PtrTwo)];
    end
    if (peek_idx < stack_ptr_q) begin
      peek_data = mem_q[AW'(stack_ptr_q - PtrOne - peek_idx)];
    end
  end

  assign stack_ptr = stack_ptr_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/regfile_stack.md
Name: regfile_stack

Overview:
Register-file LIFO stack that answers the push/pop commands issued by the calculator control FSM. On each clock edge it performs at most one operation and presents the top two entries combinationally from the updated state. It also provides occupancy, full/empty status and sticky overflow/underflow flags. A third indexed read port lets display logic inspect any live entry.

Parameters:
WIDTH, 32, data width of each entry.
DEPTH, 32, number of entries; legal range 2..(2**PTR_W - 1).
PTR_W, 6, width of stack_ptr and peek_idx.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous active-low reset; sampled on rising edge of clk.
push  input  WIDTH-independent 1  push request; one operation per cycle asserted (level-sampled).
pop  input  1  pop request; one operation per cycle asserted (level-sampled).
data_in  input  WIDTH  value written on push or replace.
stack_top  output  WIDTH  entry at depth 0 (most recent).
stack_top_minus_one  output  WIDTH  entry at depth 1.
full  output  1  stack_ptr == DEPTH.
empty  output  1  stack_ptr == 0.
stack_ptr  output  PTR_W  current entry count.
overflow  output  1  sticky: a push was rejected.
underflow  output  1  sticky: a pop was rejected.
clr_err  input  1  clears overflow and underflow.
peek_idx  input  PTR_W  depth index for the peek port (0 = top).
peek_data  output  WIDTH  entry at depth peek_idx.

Behaviour:
- Reset (rst==0 at edge): stack_ptr=0, overflow=0, underflow=0. Memory array is not cleared; all data outputs read 0 because of masking. Reset overrides push/pop/clr_err in the same cycle.
- Command decode per edge (rst==1):
  - push=1, pop=0, not full: mem[stack_ptr] <= data_in; stack_ptr +1.
  - push=1, pop=0, full: no write; stack_ptr unchanged; overflow <= 1.
  - push=0, pop=1, not empty: stack_ptr -1. Popped entry is not cleared.
  - push=0, pop=1, empty: stack_ptr unchanged; underflow <= 1.
  - push=1, pop=1, not empty: replace top, mem[stack_ptr-1] <= data_in; stack_ptr unchanged. Legal when full; no error flag is set.
  - push=1, pop=1, empty: treated as push (stack_ptr 0->1); no underflow.
  - push=0, pop=0: hold.
- Error flags: clr_err=1 clears both flags. If a new error occurs in the same cycle as clr_err, the set wins. Flags never block operations.
- Read side is combinational from registered state, so zero-latency after the edge:
  - stack_top = (stack_ptr>=1) ? mem[stack_ptr-1] : 0.
  - stack_top_minus_one = (stack_ptr>=2) ? mem[stack_ptr-2] : 0.
  - peek_data = (peek_idx < stack_ptr) ? mem[stack_ptr-1-peek_idx] : 0.
- full and empty are decoded from stack_ptr, never stored separately; full and empty are never both 1.
- Back-to-back operations are supported every cycle. The caller pops two operands by holding pop for two consecutive cycles.
- Pointer arithmetic must never wrap: saturation at 0 and DEPTH is guaranteed by the reject rules above.
- Internal state consists of mem[DEPTH], stack_ptr and the two error flags. Use no latches; write-enable decode is a single priority-free case on {push,pop,full,empty}.

Test Plan:
- Reset then push 0x11, 0x22, 0x33 on consecutive cycles -> after third edge: stack_top=0x33, stack_top_minus_one=0x22, stack_ptr=3, empty=0; peek_idx=2 gives 0x11, peek_idx=3 gives 0.
- From that state, pop held 2 cycles -> stack_top=0x11, stack_top_minus_one=0, stack_ptr=1. Two more pops -> empty=1, stack_ptr=0, underflow=1, stack_top=0.
- Fill with DEPTH pushes of values 1..32, then push 0xAA -> full=1, stack_ptr=32, overflow=1, stack_top=32. Then push+pop with 0xBB -> stack_top=0xBB, stack_ptr=32, no new error.
- Stack [5,7] (top 7), push+pop data_in=0x0C -> stack_top=0x0C, stack_top_minus_one=5, stack_ptr=2. Empty stack with push+pop 0x9 -> stack_ptr=1, stack_top=9, underflow stays 0.
- With underflow=1, assert clr_err together with a pop on empty -> underflow remains 1. Next cycle clr_err alone -> underflow=0, overflow=0.
- Push 3 values, assert rst=0 for one cycle while push=1 -> stack_ptr=0, all outputs 0, no write; rst=1 and push 0x44 -> stack_top=0x44, stack_ptr=1.
